// File: rtl/pcie_pwr_seq_ctrl.sv
// Multi-slot PCIe power sequencer: one FSM per slot driving rails, REFCLK OE and PERST_n.
// Optional macro PCIE_PWR_SEQ_STAGGER_EN serialises rail ramp-up across slots (inrush limit).
module pcie_pwr_seq_ctrl #(
  parameter int N_SLOTS             = 2,
  parameter int CNT_W               = 24,
  parameter int T_PGOOD_TIMEOUT_CYC = 1000,
  parameter int T_RAIL_STABLE_CYC   = 1000,
  parameter int T_CLK_TO_PERST_CYC  = 10000,
  parameter int T_GRST_TO_PERST_CYC = 10000000,
  parameter int T_PERST_TO_OFF_CYC  = 100
) (
  input  logic                   ref_clk_en,
  input  logic                   GRST_n,
  input  logic [N_SLOTS-1:0]     slot_en_req_i,
  input  logic [N_SLOTS-1:0]     pgood_3v3_i,
  input  logic [N_SLOTS-1:0]     pgood_1v5_i,
  input  logic [N_SLOTS-1:0]     fault_clr_i,
  output logic [N_SLOTS-1:0]     vdd_3v3_en_o,
  output logic [N_SLOTS-1:0]     vdd_1v5_en_o,
  output logic [N_SLOTS-1:0]     refclk_oe_o,
  output logic [N_SLOTS-1:0]     PERST_n_o,
  output logic [N_SLOTS-1:0]     slot_active_o,
  output logic [N_SLOTS-1:0]     slot_fault_o,
  output logic [3*N_SLOTS-1:0]   state_dbg_o
);

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_RAMP     = 3'd1,
    S_STABLE   = 3'd2,
    S_CLK_WAIT = 3'd3,
    S_ACTIVE   = 3'd4,
    S_PDOWN    = 3'd5,
    S_FAULT    = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] PGOOD_LAST = CNT_W'(T_PGOOD_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] RAIL_LAST  = CNT_W'(T_RAIL_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CLK_LAST   = CNT_W'(T_CLK_TO_PERST_CYC - 1);
  localparam logic [CNT_W-1:0] GRST_LAST  = CNT_W'(T_GRST_TO_PERST_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(T_PERST_TO_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e             state_q [N_SLOTS];
  state_e             state_d [N_SLOTS];
  logic [CNT_W-1:0]   cnt_q   [N_SLOTS];
  logic [CNT_W-1:0]   cnt_d   [N_SLOTS];
  logic [CNT_W-1:0]   grst_cnt_q, grst_cnt_d;
  logic               grst_done;
  logic [N_SLOTS-1:0] ramp_ok;
  logic [N_SLOTS-1:0] rail_en_q, refclk_oe_q, perst_n_q, active_q, fault_q;

  // The global counter parks at its terminal value, so grst_done stays set until reset.
  assign grst_done  = (grst_cnt_q == GRST_LAST);
  assign grst_cnt_d = grst_done ? grst_cnt_q : grst_cnt_q + CNT_W'(1);

`ifdef PCIE_PWR_SEQ_STAGGER_EN
  logic [N_SLOTS-1:0] busy, want;
  logic               lower_want;

  always_comb begin
    busy       = '0;
    want       = '0;
    ramp_ok    = '0;
    lower_want = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      busy[i] = (state_q[i] == S_RAMP) || (state_q[i] == S_STABLE);
      want[i] = (state_q[i] == S_OFF) && slot_en_req_i[i];
    end
    // A requesting slot is itself OFF, so any busy slot is "another" slot.
    for (int i = 0; i < N_SLOTS; i++) begin
      ramp_ok[i] = (busy == '0) && !lower_want;
      lower_want = lower_want | want[i];
    end
  end
`else
  assign ramp_ok = '1;
`endif

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        S_OFF:      if (slot_en_req_i[i] && ramp_ok[i]) state_d[i] = S_RAMP;
        S_RAMP: begin
          if (!slot_en_req_i[i])                       state_d[i] = S_PDOWN;
          else if (pgood_3v3_i[i] && pgood_1v5_i[i])   state_d[i] = S_STABLE;
          else if (cnt_q[i] == PGOOD_LAST)             state_d[i] = S_FAULT;
        end
        S_STABLE: begin
          if (!(pgood_3v3_i[i] && pgood_1v5_i[i]))     state_d[i] = S_FAULT;
          else if (!slot_en_req_i[i])                  state_d[i] = S_PDOWN;
          else if (cnt_q[i] == RAIL_LAST)              state_d[i] = S_CLK_WAIT;
        end
        S_CLK_WAIT: begin
          if (!(pgood_3v3_i[i] && pgood_1v5_i[i]))     state_d[i] = S_FAULT;
          else if (!slot_en_req_i[i])                  state_d[i] = S_PDOWN;
          else if (cnt_q[i] >= CLK_LAST && grst_done)  state_d[i] = S_ACTIVE;
        end
        S_ACTIVE: begin
          if (!(pgood_3v3_i[i] && pgood_1v5_i[i]))     state_d[i] = S_FAULT;
          else if (!slot_en_req_i[i])                  state_d[i] = S_PDOWN;
        end
        // Rails are being shut down here, so pgood loss and new requests are ignored.
        S_PDOWN:    if (cnt_q[i] == OFF_LAST) state_d[i] = S_OFF;
        S_FAULT:    if (fault_clr_i[i] && !slot_en_req_i[i]) state_d[i] = S_OFF;
        default:    state_d[i] = S_OFF;
      endcase
      if (state_d[i] != state_q[i])  cnt_d[i] = '0;
      else if (cnt_q[i] == CNT_MAX)  cnt_d[i] = cnt_q[i];
      else                           cnt_d[i] = cnt_q[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge ref_clk_en) begin
    if (!GRST_n) begin
      grst_cnt_q  <= '0;
      rail_en_q   <= '0;
      refclk_oe_q <= '0;
      perst_n_q   <= '0;
      active_q    <= '0;
      fault_q     <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i] <= S_OFF;
        cnt_q[i]   <= '0;
      end
    end else begin
      grst_cnt_q <= grst_cnt_d;
      for (int i = 0; i < N_SLOTS; i++) begin
        state_q[i]     <= state_d[i];
        cnt_q[i]       <= cnt_d[i];
        // Outputs decode the next state so they change on the same edge as the state.
        rail_en_q[i]   <= (state_d[i] != S_OFF) && (state_d[i] != S_FAULT);
        refclk_oe_q[i] <= (state_d[i] == S_CLK_WAIT) || (state_d[i] == S_ACTIVE) ||
                          (state_d[i] == S_PDOWN);
        perst_n_q[i]   <= (state_d[i] == S_ACTIVE);
        active_q[i]    <= (state_d[i] == S_ACTIVE);
        fault_q[i]     <= (state_d[i] == S_FAULT);
      end
    end
  end

  always_comb begin
    state_dbg_o = '0;
    for (int i = 0; i < N_SLOTS; i++) state_dbg_o[3*i +: 3] = state_q[i];
  end

  assign vdd_3v3_en_o  = rail_en_q;
  assign vdd_1v5_en_o  = rail_en_q;
  assign refclk_oe_o   = refclk_oe_q;
  assign PERST_n_o     = perst_n_q;
  assign slot_active_o = active_q;
  assign slot_fault_o  = fault_q;

endmodule

// File: tb/tb_pcie_pwr_seq_ctrl.sv
// Directed bench for pcie_pwr_seq_ctrl: expected per-slot output changes (value + edge number)
// are queued by the stimulus and consumed by an independent monitor on every observed change.
module tb_pcie_pwr_seq_ctrl;

  localparam int W = 38;

  // Per-slot output tuple {3v3, 1v5, refclk_oe, PERST_n, active, fault}
  localparam logic [5:0] O_OFF   = 6'b000000;
  localparam logic [5:0] O_RAMP  = 6'b110000;
  localparam logic [5:0] O_CW    = 6'b111000;
  localparam logic [5:0] O_ACT   = 6'b111110;
  localparam logic [5:0] O_PDOWN = 6'b111000;
  localparam logic [5:0] O_FAULT = 6'b000001;

  logic       clk;
  logic       grst_n;
  logic [1:0] req, pg3, pg15, clr;
  logic [1:0] en3, en15, oe, perst_n, act, flt;
  logic [5:0] dbg;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic mon_en = 1'b0;
  logic [5:0] prev0, prev1;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  pcie_pwr_seq_ctrl #(
    .N_SLOTS(2), .CNT_W(24), .T_PGOOD_TIMEOUT_CYC(8), .T_RAIL_STABLE_CYC(4),
    .T_CLK_TO_PERST_CYC(10), .T_GRST_TO_PERST_CYC(50), .T_PERST_TO_OFF_CYC(3)
  ) dut (
    .ref_clk_en(clk), .GRST_n(grst_n),
    .slot_en_req_i(req), .pgood_3v3_i(pg3), .pgood_1v5_i(pg15), .fault_clr_i(clr),
    .vdd_3v3_en_o(en3), .vdd_1v5_en_o(en15), .refclk_oe_o(oe), .PERST_n_o(perst_n),
    .slot_active_o(act), .slot_fault_o(flt), .state_dbg_o(dbg)
  );

  // Clock / edge counter: at a negedge, cyc equals the number of posedges so far.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic exp_ev(input int s, input int at, input logic [5:0] v);
    if (s == 0) exp_q0.push_back({at[31:0], v});
    else        exp_q1.push_back({at[31:0], v});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Scoreboard monitor
  task automatic ev_check(input int s, input logic [5:0] cur);
    logic [W-1:0] e;
    logic         have;
    have = 1'b0;
    e    = '0;
    if (s == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
    if (s == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL slot%0d_event: got %b @%0d expected no change", s, cur, cyc);
    end else if (e[5:0] !== cur || e[W-1:6] !== cyc) begin
      errors++;
      $display("FAIL slot%0d_event: got %b @%0d expected %b @%0d", s, cur, cyc, e[5:0], e[W-1:6]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if ({en3[0], en15[0], oe[0], perst_n[0], act[0], flt[0]} !== prev0) begin
        prev0 = {en3[0], en15[0], oe[0], perst_n[0], act[0], flt[0]};
        ev_check(0, prev0);
      end
      if ({en3[1], en15[1], oe[1], perst_n[1], act[1], flt[1]} !== prev1) begin
        prev1 = {en3[1], en15[1], oe[1], perst_n[1], act[1], flt[1]};
        ev_check(1, prev1);
      end
    end
  end

  // Driver
  initial begin
    int n;
    int rel;
    logic [W-1:0] e;
    grst_n = 1'b0; req = '0; pg3 = '0; pg15 = '0; clr = '0;
    repeat (3) @(negedge clk);

    chk("rst_3v3", 32'(en3), 32'h0);
    chk("rst_1v5", 32'(en15), 32'h0);
    chk("rst_oe", 32'(oe), 32'h0);
    chk("rst_perst", 32'(perst_n), 32'h0);
    chk("rst_active", 32'(act), 32'h0);
    chk("rst_fault", 32'(flt), 32'h0);
    chk("rst_state", 32'(dbg), 32'h0);
    prev0 = O_OFF; prev1 = O_OFF; mon_en = 1'b1;

    // GRST gate: early request, PERST_n held until 50 edges after release
    grst_n = 1'b1; rel = cyc;
    @(negedge clk); n = cyc;
    req[0] = 1'b1; pg3[0] = 1'b1; pg15[0] = 1'b1;
    exp_ev(0, n + 1, O_RAMP);
    exp_ev(0, n + 6, O_CW);
    exp_ev(0, rel + 50, O_ACT);
    goto(rel + 55);

    // Power-down from ACTIVE
    n = cyc; req[0] = 1'b0;
    exp_ev(0, n + 1, O_PDOWN);
    exp_ev(0, n + 4, O_OFF);
    goto(n + 8); pg3[0] = 1'b0; pg15[0] = 1'b0;

    // Nominal: both slots requested together
    n = cyc; req = 2'b11; pg3[1] = 1'b1; pg15[1] = 1'b1;
    exp_ev(0, n + 1, O_RAMP);
    exp_ev(0, n + 7, O_CW);
    exp_ev(0, n + 17, O_ACT);
`ifdef PCIE_PWR_SEQ_STAGGER_EN
    exp_ev(1, n + 8, O_RAMP);
    exp_ev(1, n + 13, O_CW);
    exp_ev(1, n + 23, O_ACT);
`else
    exp_ev(1, n + 1, O_RAMP);
    exp_ev(1, n + 6, O_CW);
    exp_ev(1, n + 16, O_ACT);
`endif
    goto(n + 2); pg3[0] = 1'b1; pg15[0] = 1'b1;
    goto(n + 30);

    // Slot0: pgood loss together with request drop -> FAULT wins; slot1 must not move
    n = cyc; pg3[0] = 1'b0; pg15[0] = 1'b0; req[0] = 1'b0;
    exp_ev(0, n + 1, O_FAULT);
    goto(n + 2); clr[0] = 1'b1;
    exp_ev(0, n + 3, O_OFF);
    goto(n + 3); clr[0] = 1'b0;

    // Slot1 power-down; pgood loss during PDOWN is ignored
    goto(n + 6); n = cyc; req[1] = 1'b0;
    exp_ev(1, n + 1, O_PDOWN);
    exp_ev(1, n + 4, O_OFF);
    goto(n + 2); pg3[1] = 1'b0; pg15[1] = 1'b0;

    // Slot1 pgood timeout, fault_clr ignored while requested
    goto(n + 8); n = cyc; req[1] = 1'b1;
    exp_ev(1, n + 1, O_RAMP);
    exp_ev(1, n + 9, O_FAULT);
    goto(n + 11); clr[1] = 1'b1;
    goto(n + 12); clr[1] = 1'b0;
    goto(n + 14); req[1] = 1'b0;
    goto(n + 16); clr[1] = 1'b1;
    exp_ev(1, n + 17, O_OFF);
    goto(n + 17); clr[1] = 1'b0;

    // Reset while slot0 is in CLK_WAIT; GRST gate re-applies after release
    goto(n + 20); n = cyc;
    req[0] = 1'b1; pg3[0] = 1'b1; pg15[0] = 1'b1;
    exp_ev(0, n + 1, O_RAMP);
    exp_ev(0, n + 6, O_CW);
    goto(n + 8); grst_n = 1'b0;
    exp_ev(0, n + 9, O_OFF);
    goto(n + 9); grst_n = 1'b1; rel = cyc;
    exp_ev(0, rel + 1, O_RAMP);
    exp_ev(0, rel + 6, O_CW);
    exp_ev(0, rel + 50, O_ACT);
    goto(rel + 55);

    chk("end_perst", 32'(perst_n), 32'h1);
    chk("end_fault", 32'(flt), 32'h0);
    chk("end_state", 32'(dbg), 32'h04);

    mon_en = 1'b0;
    while (exp_q0.size() > 0) begin
      e = exp_q0.pop_front(); checks++; errors++;
      $display("FAIL slot0_missing: got no change expected %b @%0d", e[5:0], e[W-1:6]);
    end
    while (exp_q1.size() > 0) begin
      e = exp_q1.pop_front(); checks++; errors++;
      $display("FAIL slot1_missing: got no change expected %b @%0d", e[5:0], e[W-1:6]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
